jkff_bank_counter: RTL and testbench
====================================

# jkff_bank_counter

Parametrised successor to the single JK flip-flop: a WIDTH-bit bank of JK flip-flops sharing one clock and one asynchronous reset. Each cycle the bank acts in one of four modes: raw per-bit JK, modulo up-count, modulo down-count, or parallel load. Counting either wraps or saturates at a programmable ceiling. It sits beside the existing flip-flop primitives as the general-purpose state/counter element for lab datapaths (decade counters, timers, toggle registers).

## Interface
- WIDTH, 4: number of flip-flops; 1 ≤ WIDTH ≤ 16.
- MAX_COUNT, 2**WIDTH-1: counting ceiling; 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- asyncReset  input  1  asynchronous, active-high reset; takes effect immediately, independent of clk.
- en  input  1  cycle enable; 0 = hold all state; ovf is cleared.
- mode  input  2  00 raw JK, 01 count up, 10 count down, 11 load.
- J  input  WIDTH  per-bit J, used only in mode 00.
- K  input  WIDTH  per-bit K, used only in mode 00.
- D  input  WIDTH  parallel load value, used only in mode 11.
- Q  output  WIDTH  registered state.
- notQ  output  WIDTH  always the bitwise complement ~Q.
- tc  output  1  combinational terminal count; see Operation.
- ovf  output  1  registered one-cycle pulse after a wrap or saturation event.

## Operation
- Reset (asyncReset=1): Q=0, notQ=all ones, ovf=0. tc follows its equation.
  - While reset is high, clock edges have no effect.
- en=0: Q holds and ovf←0, in every mode.
- Mode 00, raw JK, per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: Q[i]←0.
  - J=1, K=0: Q[i]←1.
  - J=1, K=1: toggle.
  - No clamping; any of 2**WIDTH values is legal. ovf←0.
- Mode 01, up:
  - Q<MAX_COUNT: Q←Q+1, ovf←0.
  - Q≥MAX_COUNT, SATURATE=0: Q←0, ovf←1.
  - Q≥MAX_COUNT, SATURATE=1: Q←MAX_COUNT, ovf←1.
- Mode 10, down:
  - Q>MAX_COUNT: Q←MAX_COUNT, ovf←0. This is the recovery path for out-of-range raw values.
  - 0<Q≤MAX_COUNT: Q←Q-1, ovf←0.
  - Q=0, SATURATE=0: Q←MAX_COUNT, ovf←1.
  - Q=0, SATURATE=1: Q stays 0, ovf←1.
- Mode 11, load:
  - Q←min(D, MAX_COUNT), ovf←0.
  - Loading D>MAX_COUNT clamps silently.
- tc = en & ((mode==01 & Q≥MAX_COUNT) | (mode==10 & Q==0)).
  - tc is the lookahead for the ovf event on the next edge. It is used for cascading banks: tc drives the next bank's en.
- Arithmetic uses WIDTH+1 bits internally. Comparisons are unsigned.

## Timing
- Q, notQ and ovf change only on the rising clk edge or on the asyncReset assertion.
- Latency is one cycle from inputs sampled at an edge to the new Q.
- ovf is high for exactly one cycle per event. Back-to-back events give consecutive high cycles, for example when saturated with up held.
- tc is combinational from en, mode and Q, with no registered delay.
- Reset mid-count:
  - Q goes to 0 asynchronously, within the same delta, not at the next edge.
  - On deassertion, the first rising edge with asyncReset=0 performs a normal update from Q=0.
- Reset deasserted coincident with an edge: that edge is ignored, and Q stays 0 until the following edge.

## Test plan
- Reset: assert asyncReset between edges while Q=4'h7 -> Q=0 and notQ=4'hF immediately; ovf=0; edges during reset leave Q=0.
- Raw JK (WIDTH=4): Q=0, then J=4'b1111, K=0 -> 4'hF; then J=K=4'b1010 -> 4'h5; then J=0, K=4'b0001 -> 4'h4; notQ=~Q every cycle.
- Decade wrap (MAX_COUNT=9, SATURATE=0):
  - Up from 0: 0..9, then 0; tc high while Q=9; ovf high the single cycle after the 9→0 edge.
  - Down from 0 -> 9 with ovf pulse.
- Saturation (MAX_COUNT=9, SATURATE=1):
  - Up held at 9 -> Q stays 9 and ovf stays high every cycle.
  - Down from 1 -> 0, then stays 0 with ovf high.
- Load and clamp (MAX_COUNT=9): D=5 -> Q=5; D=4'hC -> Q=9. Raw-set Q=4'hE, then down -> Q=9, ovf=0; raw-set Q=4'hE, then up -> Q=0, ovf=1.
- Enable: en=0 for 3 cycles in each mode -> Q unchanged, tc=0, ovf=0. Re-enabling resumes counting from the held value.

Source files
------------

// File: rtl/jkff_bank_counter.sv
// jkff_bank_counter: WIDTH-bit bank of JK flip-flops with raw JK, modulo
// up/down counting and parallel load modes. Counting wraps or saturates at
// MAX_COUNT, and tc gives a one-edge lookahead of the ovf event so that banks
// can be cascaded.
module jkff_bank_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             asyncReset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // One extra bit keeps the increment and the ceiling compares free of overflow.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

  logic [WIDTH:0]   qExt;
  logic [WIDTH:0]   dExt;
  logic [WIDTH:0]   qInc;
  logic [WIDTH:0]   qDec;
  logic [WIDTH-1:0] qNext;
  logic             ovfNext;

  assign qExt = {1'b0, Q};
  assign dExt = {1'b0, D};
  assign qInc = qExt + 1'b1;
  assign qDec = qExt - 1'b1;

  // Next-state selection for the bank and the overflow event.
  always_comb begin
    qNext   = Q;
    ovfNext = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          qNext = (J & ~Q) | (~K & Q);
        end
        MODE_UP: begin
          if (qExt >= MAX_EXT) begin
            ovfNext = 1'b1;
            qNext   = SATURATE ? MAX_Q : '0;
          end else begin
            qNext = qInc[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          // Values above the ceiling (reachable only through raw JK) snap back in range.
          if (qExt > MAX_EXT) begin
            qNext = MAX_Q;
          end else if (Q != '0) begin
            qNext = qDec[WIDTH-1:0];
          end else begin
            ovfNext = 1'b1;
            qNext   = SATURATE ? '0 : MAX_Q;
          end
        end
        MODE_LOAD: begin
          qNext = (dExt > MAX_EXT) ? MAX_Q : D;
        end
        default: begin
          qNext = Q;
        end
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else begin
      Q   <= qNext;
      ovf <= ovfNext;
    end
  end

  // Complement output and the combinational terminal-count lookahead.
  assign notQ = ~Q;
  assign tc   = en & (((mode == MODE_UP) & (qExt >= MAX_EXT)) |
                      ((mode == MODE_DOWN) & (Q == '0)));

endmodule

// File: tb/tb_jkff_bank_counter.sv
// Scoreboard bench for jkff_bank_counter: a wrapping and a saturating decade
// bank share all inputs; the driver pushes hand-computed post-edge values and
// a monitor pops and compares them one half-cycle after each edge.
module tb_jkff_bank_counter;

  logic       clk;
  logic       asyncReset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] J, K, D;
  logic [3:0] qW, notQW, qS, notQS;
  logic       tcW, ovfW, tcS, ovfS;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  typedef struct {
    int         idx;
    logic [3:0] qW;
    logic       ovfW;
    logic       tcW;
    logic [3:0] qS;
    logic       ovfS;
    logic       tcS;
  } exp_t;

  exp_t sb[$];

  jkff_bank_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .asyncReset(asyncReset), .en(en), .mode(mode),
    .J(J), .K(K), .D(D), .Q(qW), .notQ(notQW), .tc(tcW), .ovf(ovfW)
  );

  jkff_bank_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dutSat (
    .clk(clk), .asyncReset(asyncReset), .en(en), .mode(mode),
    .J(J), .K(K), .D(D), .Q(qS), .notQ(notQS), .tc(tcS), .ovf(ovfS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chkAll(input exp_t e);
    chk("qWrap", e.idx, qW, e.qW);
    chk("notQWrap", e.idx, notQW, ~e.qW);
    chk("ovfWrap", e.idx, {3'b0, ovfW}, {3'b0, e.ovfW});
    chk("tcWrap", e.idx, {3'b0, tcW}, {3'b0, e.tcW});
    chk("qSat", e.idx, qS, e.qS);
    chk("notQSat", e.idx, notQS, ~e.qS);
    chk("ovfSat", e.idx, {3'b0, ovfS}, {3'b0, e.ovfS});
    chk("tcSat", e.idx, {3'b0, tcS}, {3'b0, e.tcS});
  endtask

  // Monitor: half a cycle after each edge, compare against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) chkAll(sb.pop_front());
  end

  // Drive one cycle of inputs and record the state expected after the next edge.
  task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] j, input logic [3:0] k,
                     input logic [3:0] d, input logic [3:0] eqW, input logic eoW, input logic etW,
                     input logic [3:0] eqS, input logic eoS, input logic etS);
    exp_t x;
    @(negedge clk);
    #1;
    en = e; mode = m; J = j; K = k; D = d;
    step++;
    x.idx = step; x.qW = eqW; x.ovfW = eoW; x.tcW = etW;
    x.qS = eqS; x.ovfS = eoS; x.tcS = etS;
    sb.push_back(x);
  endtask

  task automatic directChk(input logic [3:0] eq);
    exp_t x;
    step++;
    x.idx = step; x.qW = eq; x.ovfW = 1'b0; x.tcW = 1'b0;
    x.qS = eq; x.ovfS = 1'b0; x.tcS = 1'b0;
    chkAll(x);
  endtask

  initial begin
    asyncReset = 1'b1; en = 1'b0; mode = 2'b11; J = '0; K = '0; D = '0;
    repeat (2) @(negedge clk);
    #1 directChk(4'h0);
    asyncReset = 1'b0;

    // Reset mid-count from Q=7 takes effect immediately and survives edges.
    cyc(1, 2'b11, 4'h0, 4'h0, 4'h7, 4'h7, 0, 0, 4'h7, 0, 0);
    @(negedge clk);
    #2 asyncReset = 1'b1;
    #1 directChk(4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    directChk(4'h0);
    #1 asyncReset = 1'b0;

    // Raw JK: set all, toggle 1010, clear bit 0.
    cyc(1, 2'b00, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0);
    cyc(1, 2'b00, 4'hA, 4'hA, 4'h0, 4'h5, 0, 0, 4'h5, 0, 0);
    cyc(1, 2'b00, 4'h0, 4'h1, 4'h0, 4'h4, 0, 0, 4'h4, 0, 0);

    // Decade up from 0; wrap versus saturate at 9.
    cyc(1, 2'b11, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
    for (int k = 1; k <= 9; k++)
      cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'(k), 0, (k == 9), 4'(k), 0, (k == 9));
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h9, 1, 1);
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0, 4'h9, 1, 1);
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0, 4'h9, 1, 1);

    // Down from 0: wrap to 9 versus hold at 0.
    cyc(1, 2'b11, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
    cyc(1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h9, 1, 0, 4'h0, 1, 1);
    cyc(1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h8, 0, 0, 4'h0, 1, 1);

    // Down from 1 reaches 0 without an event, then the event fires.
    cyc(1, 2'b11, 4'h0, 4'h0, 4'h1, 4'h1, 0, 0, 4'h1, 0, 0);
    cyc(1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 4'h0, 0, 1);
    cyc(1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h9, 1, 0, 4'h0, 1, 1);

    // Load, clamp, and recovery of out-of-range raw values.
    cyc(1, 2'b11, 4'h0, 4'h0, 4'h5, 4'h5, 0, 0, 4'h5, 0, 0);
    cyc(1, 2'b11, 4'h0, 4'h0, 4'hC, 4'h9, 0, 0, 4'h9, 0, 0);
    cyc(1, 2'b00, 4'hE, 4'h1, 4'h0, 4'hE, 0, 0, 4'hE, 0, 0);
    cyc(1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h9, 0, 0, 4'h9, 0, 0);
    cyc(1, 2'b00, 4'hE, 4'h1, 4'h0, 4'hE, 0, 1'b0, 4'hE, 0, 1'b0);
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h9, 1, 1);

    // Enable low in every mode holds Q and clears ovf and tc.
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 3; c++)
        cyc(0, 2'(m), 4'hF, 4'hF, 4'h3, 4'h0, 0, 0, 4'h9, 0, 0);

    // Re-enable resumes from the held values.
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0, 4'h9, 1, 1);
    cyc(1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0, 4'h9, 1, 1);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
